vga_pattern_sequencer: RTL



---
 rtl/vga_pattern_sequencer_if.sv | 21 ++
 rtl/vga_pattern_sequencer.sv | 114 +++++++++++
 2 files changed

// File: rtl/vga_pattern_sequencer_if.sv
// Control bundle between the board buttons / sync generator and the pattern sequencer.
// The slave modport is the sequencer side; the master side drives the inputs.
interface vga_pattern_sequencer_if;
  logic       frame_start;
  logic       btn_next;
  logic       btn_mode;
  logic [2:0] pattern_sel;
  logic       pattern_load;
  logic       auto_mode;
  logic       pending;

  modport master (
    output frame_start, btn_next, btn_mode,
    input  pattern_sel, pattern_load, auto_mode, pending
  );

  modport slave (
    input  frame_start, btn_next, btn_mode,
    output pattern_sel, pattern_load, auto_mode, pending
  );
endinterface

// File: rtl/vga_pattern_sequencer.sv
// Selects one of eight VGA test patterns; manual and timed changes are applied
// only on frame_start so a displayed frame never mixes two patterns.
module vga_pattern_sequencer #(
  parameter int FRAMES_PER_PATTERN = 60,
  parameter int DEBOUNCE_CYCLES    = 250000
) (
  input  logic                    clk,
  input  logic                    rst,
  vga_pattern_sequencer_if.slave  bus
);
  localparam int CNT_W = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;
  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_PATTERN - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {RUN, PEND} state_t;

  logic [1:0] btn_raw;
  logic [1:0] btn_evt;

  assign btn_raw = {bus.btn_mode, bus.btn_next};

  // Per button: 2-flop synchronizer, stability counter, rising-edge press pulse.
  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic            sync1_q, sync2_q, db_q, evt_q;
    logic [DB_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        db_q    <= 1'b0;
        evt_q   <= 1'b0;
        cnt_q   <= '0;
      end else begin
        sync1_q <= btn_raw[gi];
        sync2_q <= sync1_q;
        evt_q   <= 1'b0;
        if (sync2_q != db_q) begin
          if (cnt_q == DB_LAST) begin
            db_q  <= sync2_q;
            evt_q <= sync2_q;
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end else begin
          cnt_q <= '0;
        end
      end
    end

    assign btn_evt[gi] = evt_q;
  end

  state_t           state_q, state_d;
  logic [2:0]       sel_q, sel_d;
  logic             load_q, load_d;
  logic             auto_q, auto_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             expiry, advance;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    load_d      = 1'b0;
    auto_d      = auto_q;
    frame_cnt_d = frame_cnt_q;

    expiry  = bus.frame_start && auto_q && (frame_cnt_q == CNT_LAST);
    advance = bus.frame_start && ((state_q == PEND) || expiry);

    case (state_q)
      RUN:     if (btn_evt[0]) state_d = PEND;
      PEND:    if (bus.frame_start) state_d = RUN;
      default: state_d = RUN;
    endcase

    if (advance) begin
      sel_d       = sel_q + 3'd1;
      load_d      = 1'b1;
      frame_cnt_d = '0;
    end else if (bus.frame_start && auto_q && (frame_cnt_q != CNT_LAST)) begin
      frame_cnt_d = frame_cnt_q + 1'b1;
    end

    // A mode toggle restarts the hold interval even when it coincides with an advance.
    if (btn_evt[1]) begin
      auto_d      = ~auto_q;
      frame_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      sel_q       <= 3'd0;
      load_q      <= 1'b0;
      auto_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      load_q      <= load_d;
      auto_q      <= auto_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign bus.pattern_sel  = sel_q;
  assign bus.pattern_load = load_q;
  assign bus.auto_mode    = auto_q;
  assign bus.pending      = (state_q == PEND);
endmodule
